sparse_bitmap_decoder: RTL and testbench

//  Producer side of the decoder->comparator stream. Walks one bitmap-compressed sparse vector in SRAM and

---
 rtl/sparse_bitmap_decoder.sv | 187 ++++++++++++++++++
 tb/tb_sparse_bitmap_decoder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_bitmap_decoder.sv
// sparse_bitmap_decoder: walks one bitmap-compressed sparse vector in SRAM and
// streams one {index, value, done=0} entry per nonzero element in ascending
// index order, followed by a single {all-ones, 0, done=1} terminator.
//
// Ports:
//   mac_clk, mac_rst      clock, asynchronous active-low reset
//   start_i               begin decoding (sampled only when idle)
//   base_addr_i           SRAM address of the first bitmap word
//   num_chunks_i          number of bitmap chunks in the vector
//   busy_o                high from start accept until the done entry is accepted
//   sram_rd_en_o          SRAM read strobe (data returns one cycle later)
//   sram_addr_o           SRAM read address (0 when not reading)
//   sram_rdata_i          SRAM read data
//   dec_valid_o           output entry valid
//   dec_ready_i           downstream ready
//   dec_data_o            output entry {index, value, done}

package sparse_mac_pkg;
    localparam int unsigned IDX_W = 16;
    localparam int unsigned VAL_W = 16;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [VAL_W-1:0] value;
        logic             done;
    } decoder_data_t;
endpackage

module sparse_bitmap_decoder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned VAL_W  = 16
) (
    input  logic                          mac_clk,
    input  logic                          mac_rst,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             base_addr_i,
    input  logic [ADDR_W-1:0]             num_chunks_i,
    output logic                          busy_o,
    output logic                          sram_rd_en_o,
    output logic [ADDR_W-1:0]             sram_addr_o,
    input  logic [DATA_W-1:0]             sram_rdata_i,
    output logic                          dec_valid_o,
    input  logic                          dec_ready_i,
    output sparse_mac_pkg::decoder_data_t dec_data_o
);

    localparam int unsigned POS_W = $clog2(DATA_W);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_BMAP   = 3'd1;
    localparam logic [2:0] WAIT_BMAP = 3'd2;
    localparam logic [2:0] SCAN      = 3'd3;
    localparam logic [2:0] WAIT_VAL  = 3'd4;
    localparam logic [2:0] OUT       = 3'd5;
    localparam logic [2:0] EMIT_DONE = 3'd6;
    localparam logic [2:0] FIN       = 3'd7;

    logic [2:0]          state, state_d;
    logic [ADDR_W-1:0]   ptr, ptr_d;
    logic [ADDR_W-1:0]   chunk, chunk_d;
    logic [ADDR_W-1:0]   nchunks, nchunks_d;
    logic [DATA_W-1:0]   bmap, bmap_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic                busy_d, rd_en_d, valid_d;
    logic [ADDR_W-1:0]   addr_d;
    sparse_mac_pkg::decoder_data_t data_d;
    logic [POS_W-1:0]    pos;
    logic                accept;

    // Lowest set bit of the remaining bitmap.
    always_comb begin
        pos = '0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            if (bmap[i]) pos = POS_W'(i);
        end
    end

    assign accept = dec_valid_o & dec_ready_i;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        chunk_d   = chunk;
        nchunks_d = nchunks;
        bmap_d    = bmap;
        idx_d     = idx;
        busy_d    = busy_o;
        valid_d   = dec_valid_o;
        data_d    = dec_data_o;

        case (state)
            IDLE: begin
                if (start_i) begin
                    ptr_d     = base_addr_i;
                    chunk_d   = '0;
                    nchunks_d = num_chunks_i;
                    busy_d    = 1'b1;
                    state_d   = (num_chunks_i == '0) ? EMIT_DONE : RD_BMAP;
                end
            end
            RD_BMAP: begin
                ptr_d   = ptr + ADDR_W'(1);
                state_d = WAIT_BMAP;
            end
            WAIT_BMAP: begin
                bmap_d  = sram_rdata_i;
                state_d = SCAN;
            end
            SCAN: begin
                if (bmap != '0) begin
                    ptr_d   = ptr + ADDR_W'(1);
                    bmap_d  = bmap & (bmap - DATA_W'(1));
                    idx_d   = IDX_W'(chunk) * IDX_W'(DATA_W) + IDX_W'(pos);
                    state_d = WAIT_VAL;
                end else begin
                    chunk_d = chunk + ADDR_W'(1);
                    state_d = (chunk + ADDR_W'(1) == nchunks) ? EMIT_DONE : RD_BMAP;
                end
            end
            WAIT_VAL: begin
                data_d.index = idx;
                data_d.value = sram_rdata_i[VAL_W-1:0];
                data_d.done  = 1'b0;
                valid_d      = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = SCAN;
                end
            end
            EMIT_DONE: begin
                data_d.index = '1;
                data_d.value = '0;
                data_d.done  = 1'b1;
                valid_d      = 1'b1;
                state_d      = FIN;
            end
            FIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read strobe is registered, so it is decoded from the state being entered.
        rd_en_d = (state_d == RD_BMAP) || ((state_d == SCAN) && (bmap_d != '0));
        addr_d  = rd_en_d ? ptr_d : '0;
    end

    // State and output registers.
    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            state        <= IDLE;
            ptr          <= '0;
            chunk        <= '0;
            nchunks      <= '0;
            bmap         <= '0;
            idx          <= '0;
            busy_o       <= 1'b0;
            sram_rd_en_o <= 1'b0;
            sram_addr_o  <= '0;
            dec_valid_o  <= 1'b0;
            dec_data_o   <= '0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            chunk        <= chunk_d;
            nchunks      <= nchunks_d;
            bmap         <= bmap_d;
            idx          <= idx_d;
            busy_o       <= busy_d;
            sram_rd_en_o <= rd_en_d;
            sram_addr_o  <= addr_d;
            dec_valid_o  <= valid_d;
            dec_data_o   <= data_d;
        end
    end

endmodule

// File: tb/tb_sparse_bitmap_decoder.sv
// Testbench for sparse_bitmap_decoder: SRAM model with one-cycle read latency,
// scoreboard of expected entries compared against accepted output entries.
module tb_sparse_bitmap_decoder;

    typedef sparse_mac_pkg::decoder_data_t entry_t;

    logic        mac_clk = 1'b0;
    logic        mac_rst;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [9:0]  num_chunks_i;
    logic        busy_o;
    logic        sram_rd_en_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_rdata_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    entry_t      dec_data_o;

    sparse_bitmap_decoder dut (
        .mac_clk      (mac_clk),
        .mac_rst      (mac_rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_chunks_i (num_chunks_i),
        .busy_o       (busy_o),
        .sram_rd_en_o (sram_rd_en_o),
        .sram_addr_o  (sram_addr_o),
        .sram_rdata_i (sram_rdata_i),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .dec_data_o   (dec_data_o)
    );

    always #5 mac_clk = ~mac_clk;

    logic [31:0] mem [0:1023];
    int          rd_count = 0;
    int unsigned rd_log[$];
    int          cyc = 0;

    // SRAM model: data returns one cycle after the strobe.
    always @(posedge mac_clk) begin
        cyc <= cyc + 1;
        if (sram_rd_en_o) begin
            sram_rdata_i <= mem[sram_addr_o];
            rd_count     <= rd_count + 1;
            rd_log.push_back(32'(sram_addr_o));
        end
    end

    int     checks = 0;
    int     errors = 0;
    entry_t exp_q[$];
    entry_t got_q[$];
    int     got_cyc[$];
    int     stall_err;
    int     first_valid_cyc;
    int     start_cyc;

    function automatic entry_t mk(input int idx, input int val, input bit done);
        entry_t e;
        e.index = 16'(idx);
        e.value = 16'(val);
        e.done  = done;
        return e;
    endfunction

    task automatic push_case1();
        exp_q.push_back(mk(0, 7, 0));
        exp_q.push_back(mk(2, 9, 0));
        exp_q.push_back(mk(63, 3, 0));
        exp_q.push_back(mk(16'hFFFF, 0, 1));
    endtask

    task automatic start_vec(input int base, input int n);
        start_i      = 1'b1;
        base_addr_i  = 10'(base);
        num_chunks_i = 10'(n);
        start_cyc    = cyc;
        @(posedge mac_clk); #1;
        start_i = 1'b0;
    endtask

    // Collect accepted entries until the done entry; optionally pulse start while busy.
    task automatic drain(input int stall_pct, input int budget, input int poke_at, output bit ok);
        entry_t prev;
        bit     prev_stall = 1'b0;
        bit     done_now;
        got_q.delete();
        got_cyc.delete();
        stall_err       = 0;
        first_valid_cyc = -1;
        ok              = 1'b0;
        prev            = '0;
        for (int n = 0; n < budget; n++) begin
            if (n == poke_at) begin
                start_i      = 1'b1;
                base_addr_i  = 10'h200;
                num_chunks_i = 10'd5;
            end else begin
                start_i = 1'b0;
            end
            dec_ready_i = ($urandom_range(99) >= 32'(stall_pct));
            if (prev_stall && (!dec_valid_o || dec_data_o !== prev)) stall_err++;
            if (dec_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            prev_stall = dec_valid_o && !dec_ready_i;
            prev       = dec_data_o;
            done_now   = dec_valid_o && dec_ready_i && dec_data_o.done;
            if (dec_valid_o && dec_ready_i) begin
                got_q.push_back(dec_data_o);
                got_cyc.push_back(cyc);
            end
            @(posedge mac_clk); #1;
            if (done_now) begin
                ok = 1'b1;
                break;
            end
        end
        start_i     = 1'b0;
        dec_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        mac_rst      = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        num_chunks_i = '0;
        dec_ready_i  = 1'b0;
        repeat (3) @(posedge mac_clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || dec_valid_o !== 1'b0 || sram_rd_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b valid=%b rd_en=%b expected 0 0 0", busy_o, dec_valid_o, sram_rd_en_o);
        end
        checks++;
        if (sram_addr_o !== 10'd0 || dec_data_o !== entry_t'(0)) begin
            errors++;
            $display("FAIL reset_data: addr=%0h data=%0h expected 0 0", sram_addr_o, dec_data_o);
        end
        mac_rst = 1'b1;
        @(posedge mac_clk); #1;
    endtask

    task automatic test_basic();
        bit     ok;
        int     rd0;
        entry_t ee, ge;
        push_case1();
        rd0 = rd_count;
        start_vec(16'h10, 2);
        drain(0, 200, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got no done entry expected done"); end
        checks++;
        if (first_valid_cyc - start_cyc != 5) begin
            errors++; $display("FAIL basic_latency: got %0d expected 5", first_valid_cyc - start_cyc);
        end
        checks++;
        if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 3) begin
            errors++; $display("FAIL basic_gap: got %0d entries/gap expected gap 3", got_cyc.size());
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL basic_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL basic_entry: got %0h expected %0h", ge, ee); end
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_o); end
        checks++;
        if (rd_count - rd0 != 5) begin errors++; $display("FAIL basic_reads: got %0d expected 5", rd_count - rd0); end
    endtask

    task automatic test_zero_chunks();
        bit     ok;
        int     rd0;
        entry_t ee, ge;
        exp_q.push_back(mk(16'hFFFF, 0, 1));
        rd0 = rd_count;
        start_vec(16'h40, 0);
        drain(0, 50, -1, ok);
        checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            errors++; $display("FAIL zero_latency: got %0d expected 2", first_valid_cyc - start_cyc);
        end
        checks++;
        if (rd_count - rd0 != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", rd_count - rd0); end
        checks++;
        if (!ok || got_q.size() != 1) begin
            errors++; $display("FAIL zero_count: got %0d expected 1", got_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL zero_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL zero_entry: got %0h expected %0h", ge, ee); end
            end
        end
    endtask

    task automatic test_empty_chunk();
        bit     ok;
        int     rd0, snap, hits;
        entry_t ee, ge;
        mem[10'h20] = 32'h3;  mem[10'h21] = 32'h11; mem[10'h22] = 32'h22;
        mem[10'h23] = 32'h0;
        mem[10'h24] = 32'h10; mem[10'h25] = 32'h55;
        exp_q.push_back(mk(0, 16'h11, 0));
        exp_q.push_back(mk(1, 16'h22, 0));
        exp_q.push_back(mk(68, 16'h55, 0));
        exp_q.push_back(mk(16'hFFFF, 0, 1));
        rd0  = rd_count;
        snap = rd_log.size();
        start_vec(16'h20, 3);
        drain(0, 200, -1, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL empty_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL empty_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL empty_entry: got %0h expected %0h", ge, ee); end
            end
        end
        hits = 0;
        for (int i = snap; i < rd_log.size(); i++) if (rd_log[i] == 32'h23) hits++;
        checks++;
        if (hits != 1) begin errors++; $display("FAIL empty_chunk_reads: got %0d expected 1", hits); end
        checks++;
        if (rd_count - rd0 != 6) begin errors++; $display("FAIL empty_reads: got %0d expected 6", rd_count - rd0); end
    endtask

    task automatic test_stall();
        bit     ok;
        int     rd0;
        entry_t ee, ge;
        push_case1();
        rd0 = rd_count;
        start_vec(16'h10, 2);
        drain(50, 1000, -1, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", stall_err); end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL stall_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL stall_entry: got %0h expected %0h", ge, ee); end
            end
        end
        checks++;
        if (rd_count - rd0 != 5) begin errors++; $display("FAIL stall_reads: got %0d expected 5", rd_count - rd0); end
    endtask

    task automatic test_full_bitmap();
        bit     ok;
        int     snap;
        entry_t ee, ge;
        mem[10'h100] = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            mem[10'h101 + 10'(i)] = 32'hABCD_0000 | 32'(3 * i + 1);
            exp_q.push_back(mk(i, 3 * i + 1, 0));
        end
        exp_q.push_back(mk(16'hFFFF, 0, 1));
        snap = rd_log.size();
        start_vec(16'h100, 1);
        drain(0, 400, -1, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL full_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL full_entry: got %0h expected %0h", ge, ee); end
            end
        end
        checks++;
        if (rd_log.size() - snap != 33) begin
            errors++; $display("FAIL full_reads: got %0d expected 33", rd_log.size() - snap);
        end else begin
            for (int i = 0; i < 33; i++) begin
                checks++;
                if (rd_log[snap + i] != 32'h100 + 32'(i)) begin
                    errors++; $display("FAIL full_addr: got %0h expected %0h", rd_log[snap + i], 32'h100 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit     ok;
        int     n;
        entry_t ee, ge;
        dec_ready_i = 1'b0;
        start_vec(16'h10, 2);
        n = 0;
        while (!dec_valid_o && n < 20) begin
            @(posedge mac_clk); #1;
            n++;
        end
        checks++;
        if (!dec_valid_o) begin errors++; $display("FAIL rst_mid_wait: got valid=0 expected 1"); end
        mac_rst = 1'b0;
        #1;
        checks++;
        if (dec_valid_o !== 1'b0 || busy_o !== 1'b0 || sram_rd_en_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b busy=%b rd_en=%b expected 0 0 0", dec_valid_o, busy_o, sram_rd_en_o);
        end
        @(posedge mac_clk); #1;
        mac_rst = 1'b1;
        @(posedge mac_clk); #1;
        push_case1();
        start_vec(16'h10, 2);
        drain(0, 200, -1, ok);
        checks++;
        if (!ok || first_valid_cyc - start_cyc != 5 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_restart: got latency %0d count %0d expected 5 %0d",
                     first_valid_cyc - start_cyc, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL rst_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL rst_entry: got %0h expected %0h", ge, ee); end
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit     ok;
        int     rd0;
        entry_t ee, ge;
        push_case1();
        rd0 = rd_count;
        start_vec(16'h10, 2);
        drain(0, 200, 2, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL busy_start_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            ee = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL busy_start_entry: got none expected %0h", ee);
            end else begin
                ge = got_q.pop_front();
                if (ge !== ee) begin errors++; $display("FAIL busy_start_entry: got %0h expected %0h", ge, ee); end
            end
        end
        repeat (5) @(posedge mac_clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || rd_count - rd0 != 5) begin
            errors++; $display("FAIL busy_start_idle: busy=%b reads=%0d expected 0 5", busy_o, rd_count - rd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h10] = 32'h5;
        mem[10'h11] = 32'd7;
        mem[10'h12] = 32'd9;
        mem[10'h13] = 32'h8000_0000;
        mem[10'h14] = 32'd3;
        test_reset();
        test_basic();
        test_zero_chunks();
        test_empty_chunk();
        test_stall();
        test_full_bitmap();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
